id_exe_reg: RTL and testbench

ID_EXE_REG -- requirements
Module: id_exe_reg

---
 rtl/id_exe_reg.sv | 194 +++++++++++++++++++
 tb/tb_id_exe_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: two-entry (head + skid) buffer with condition-fail nullification.
// Latency: 1 cycle from accept to out_valid when the head is free or draining.
// Backpressure: in_ready is registered and drops only when the skid entry holds an instruction.
module id_exe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CMD_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              cond_pass,
    input  logic              wb_en_i,
    input  logic              mem_r_en_i,
    input  logic              mem_w_en_i,
    input  logic              b_i,
    input  logic              s_i,
    input  logic [CMD_W-1:0]  exe_cmd_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] val_rn_i,
    input  logic [DATA_W-1:0] val_rm_i,
    input  logic [REG_AW-1:0] dest_i,
    input  logic [REG_AW-1:0] src1_i,
    input  logic [REG_AW-1:0] src2_i,
    input  logic              imm_i,
    input  logic [11:0]       shift_op_i,
    input  logic [23:0]       imm24_i,
    input  logic [3:0]        status_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_o,
    output logic              mem_r_en_o,
    output logic              mem_w_en_o,
    output logic              b_o,
    output logic              s_o,
    output logic [CMD_W-1:0]  exe_cmd_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] val_rn_o,
    output logic [DATA_W-1:0] val_rm_o,
    output logic [REG_AW-1:0] dest_o,
    output logic [REG_AW-1:0] src1_o,
    output logic [REG_AW-1:0] src2_o,
    output logic              imm_o,
    output logic [11:0]       shift_op_o,
    output logic [23:0]       imm24_o,
    output logic [3:0]        status_o,
    output logic [CNT_W-1:0]  null_cnt,
    output logic [1:0]        occupancy
);

    // One buffered instruction: control bits first, then the operand/data fields.
    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              b;
        logic              s;
        logic [CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [REG_AW-1:0] dest;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic              imm;
        logic [11:0]       shift_op;
        logic [23:0]       imm24;
        logic [3:0]        status;
    } entry_t;

    // Clear only the side-effecting control bits; data fields pass through untouched.
    function automatic entry_t kill_ctrl(input entry_t e);
        entry_t r;
        r          = e;
        r.wb_en    = 1'b0;
        r.mem_r_en = 1'b0;
        r.mem_w_en = 1'b0;
        r.b        = 1'b0;
        r.s        = 1'b0;
        r.exe_cmd  = '0;
        return r;
    endfunction

    entry_t           head_q;
    entry_t           skid_q;
    entry_t           in_entry;
    logic             head_vld;
    logic             skid_vld;
    logic             in_ready_q;
    logic [CNT_W-1:0] null_cnt_q;
    logic             accept;
    logic             xfer;
    logic             null_inc;

    assign accept   = in_valid && in_ready_q;
    assign xfer     = head_vld && out_ready;
    assign null_inc = accept && !cond_pass;

    // Assemble the incoming entry, turning a failed-condition instruction into a bubble.
    always_comb begin
        in_entry          = '0;
        in_entry.wb_en    = wb_en_i;
        in_entry.mem_r_en = mem_r_en_i;
        in_entry.mem_w_en = mem_w_en_i;
        in_entry.b        = b_i;
        in_entry.s        = s_i;
        in_entry.exe_cmd  = exe_cmd_i;
        in_entry.pc       = pc_i;
        in_entry.val_rn   = val_rn_i;
        in_entry.val_rm   = val_rm_i;
        in_entry.dest     = dest_i;
        in_entry.src1     = src1_i;
        in_entry.src2     = src2_i;
        in_entry.imm      = imm_i;
        in_entry.shift_op = shift_op_i;
        in_entry.imm24    = imm24_i;
        in_entry.status   = status_i;
        if (!cond_pass) begin
            in_entry = kill_ctrl(in_entry);
        end
    end

    // Head/skid storage: flush beats handshakes, skid drains into head before new data lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            head_q     <= kill_ctrl(head_q);
            head_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (xfer) begin
            if (skid_vld) begin
                // in_ready was low, so no accept can coincide with this move.
                head_q     <= skid_q;
                skid_vld   <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (accept) begin
                head_q <= in_entry;
            end else begin
                head_q   <= kill_ctrl(head_q);
                head_vld <= 1'b0;
            end
        end else if (accept) begin
            if (head_vld) begin
                skid_q     <= in_entry;
                skid_vld   <= 1'b1;
                in_ready_q <= 1'b0;
            end else begin
                head_q   <= in_entry;
                head_vld <= 1'b1;
            end
        end
    end

    // Saturating count of nullified accepts; a flush does not cancel the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            null_cnt_q <= '0;
        end else if (null_inc && (null_cnt_q != {CNT_W{1'b1}})) begin
            null_cnt_q <= null_cnt_q + 1'b1;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = head_vld;
    assign occupancy  = {1'b0, head_vld} + {1'b0, skid_vld};
    assign null_cnt   = null_cnt_q;

    assign wb_en_o    = head_q.wb_en;
    assign mem_r_en_o = head_q.mem_r_en;
    assign mem_w_en_o = head_q.mem_w_en;
    assign b_o        = head_q.b;
    assign s_o        = head_q.s;
    assign exe_cmd_o  = head_q.exe_cmd;
    assign pc_o       = head_q.pc;
    assign val_rn_o   = head_q.val_rn;
    assign val_rm_o   = head_q.val_rm;
    assign dest_o     = head_q.dest;
    assign src1_o     = head_q.src1;
    assign src2_o     = head_q.src2;
    assign imm_o      = head_q.imm;
    assign shift_op_o = head_q.shift_op;
    assign imm24_o    = head_q.imm24;
    assign status_o   = head_q.status;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: table of per-cycle vectors plus a counter-saturation sequence.
// Two instances share stimulus; the second has a 2-bit nullified-instruction counter.
// Outputs are sampled 1 time unit after each rising edge.
module tb_id_exe_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, cond_pass, out_ready;
    logic        wb_en_i, mem_r_en_i, mem_w_en_i, b_i, s_i;
    logic [3:0]  exe_cmd_i;
    logic [31:0] pc_i, val_rn_i, val_rm_i;
    logic [3:0]  dest_i, src1_i, src2_i, status_i;
    logic        imm_i;
    logic [11:0] shift_op_i;
    logic [23:0] imm24_i;

    // Secondary fields are tied to pc / control inputs so every output is checkable.
    assign mem_r_en_i = wb_en_i;
    assign s_i        = wb_en_i;
    assign b_i        = mem_w_en_i;
    assign val_rm_i   = pc_i << 1;
    assign dest_i     = pc_i[5:2];
    assign src1_i     = pc_i[6:3];
    assign src2_i     = pc_i[7:4];
    assign imm_i      = pc_i[2];
    assign shift_op_i = pc_i[13:2];
    assign imm24_i    = pc_i[25:2];
    assign status_i   = pc_i[5:2];

    logic        a_rdy, a_vld, a_wb, a_mr, a_mw, a_b, a_s, a_imm;
    logic [3:0]  a_cmd, a_dest, a_src1, a_src2, a_status;
    logic [31:0] a_pc, a_rn, a_rm;
    logic [11:0] a_shift;
    logic [23:0] a_imm24;
    logic [15:0] a_null;
    logic [1:0]  a_occ;

    logic        c_rdy, c_vld, c_wb, c_mr, c_mw, c_b, c_s, c_imm;
    logic [3:0]  c_cmd, c_dest, c_src1, c_src2, c_status;
    logic [31:0] c_pc, c_rn, c_rm;
    logic [11:0] c_shift;
    logic [23:0] c_imm24;
    logic [1:0]  c_null;
    logic [1:0]  c_occ;

    id_exe_reg dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .cond_pass(cond_pass), .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i),
        .mem_w_en_i(mem_w_en_i), .b_i(b_i), .s_i(s_i), .exe_cmd_i(exe_cmd_i),
        .pc_i(pc_i), .val_rn_i(val_rn_i), .val_rm_i(val_rm_i), .dest_i(dest_i),
        .src1_i(src1_i), .src2_i(src2_i), .imm_i(imm_i), .shift_op_i(shift_op_i),
        .imm24_i(imm24_i), .status_i(status_i), .out_valid(a_vld), .out_ready(out_ready),
        .wb_en_o(a_wb), .mem_r_en_o(a_mr), .mem_w_en_o(a_mw), .b_o(a_b), .s_o(a_s),
        .exe_cmd_o(a_cmd), .pc_o(a_pc), .val_rn_o(a_rn), .val_rm_o(a_rm), .dest_o(a_dest),
        .src1_o(a_src1), .src2_o(a_src2), .imm_o(a_imm), .shift_op_o(a_shift),
        .imm24_o(a_imm24), .status_o(a_status), .null_cnt(a_null), .occupancy(a_occ)
    );

    id_exe_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .cond_pass(cond_pass), .wb_en_i(wb_en_i), .mem_r_en_i(mem_r_en_i),
        .mem_w_en_i(mem_w_en_i), .b_i(b_i), .s_i(s_i), .exe_cmd_i(exe_cmd_i),
        .pc_i(pc_i), .val_rn_i(val_rn_i), .val_rm_i(val_rm_i), .dest_i(dest_i),
        .src1_i(src1_i), .src2_i(src2_i), .imm_i(imm_i), .shift_op_i(shift_op_i),
        .imm24_i(imm24_i), .status_i(status_i), .out_valid(c_vld), .out_ready(out_ready),
        .wb_en_o(c_wb), .mem_r_en_o(c_mr), .mem_w_en_o(c_mw), .b_o(c_b), .s_o(c_s),
        .exe_cmd_o(c_cmd), .pc_o(c_pc), .val_rn_o(c_rn), .val_rm_o(c_rm), .dest_o(c_dest),
        .src1_o(c_src1), .src2_o(c_src2), .imm_o(c_imm), .shift_op_o(c_shift),
        .imm24_o(c_imm24), .status_o(c_status), .null_cnt(c_null), .occupancy(c_occ)
    );

    always #5 clk = ~clk;

    logic [177:0] obs1, obs2;
    assign obs1 = {a_vld, a_rdy, a_occ, a_wb, a_mr, a_mw, a_b, a_s, a_cmd, a_pc, a_rn, a_rm,
                   a_dest, a_src1, a_src2, a_imm, a_shift, a_imm24, a_status, a_null};
    assign obs2 = {c_vld, c_rdy, c_occ, c_wb, c_mr, c_mw, c_b, c_s, c_cmd, c_pc, c_rn, c_rm,
                   c_dest, c_src1, c_src2, c_imm, c_shift, c_imm24, c_status, 14'd0, c_null};

    typedef struct {
        string       name;
        logic        rst, flush, iv, cp, ordy;
        logic [31:0] pc, rn;
        logic        wb, mw;
        logic [3:0]  cmd;
        logic        e_vld, e_rdy;
        logic [1:0]  e_occ;
        logic [31:0] e_pc, e_rn;
        logic        e_wb, e_mw;
        logic [3:0]  e_cmd;
        logic [15:0] e_null;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic r, logic fl, logic iv, logic cp, logic ordy,
                                logic [31:0] pc, logic [31:0] rn, logic wb, logic mw,
                                logic [3:0] cmd, logic evld, logic erdy, logic [1:0] eocc,
                                logic [31:0] epc, logic [31:0] ern, logic ewb, logic emw,
                                logic [3:0] ecmd, logic [15:0] enull);
        vec_t v;
        v.name = nm; v.rst = r; v.flush = fl; v.iv = iv; v.cp = cp; v.ordy = ordy;
        v.pc = pc; v.rn = rn; v.wb = wb; v.mw = mw; v.cmd = cmd;
        v.e_vld = evld; v.e_rdy = erdy; v.e_occ = eocc; v.e_pc = epc; v.e_rn = ern;
        v.e_wb = ewb; v.e_mw = emw; v.e_cmd = ecmd; v.e_null = enull;
        return v;
    endfunction

    // Expected output bundle; sat selects the 2-bit saturating counter view.
    function automatic logic [177:0] pack_exp(vec_t v, logic sat);
        logic [15:0] n;
        logic [31:0] rm;
        n  = v.e_null;
        if (sat && n > 16'd3) n = 16'd3;
        rm = v.e_pc << 1;
        return {v.e_vld, v.e_rdy, v.e_occ, v.e_wb, v.e_wb, v.e_mw, v.e_mw, v.e_wb, v.e_cmd,
                v.e_pc, v.e_rn, rm, v.e_pc[5:2], v.e_pc[6:3], v.e_pc[7:4], v.e_pc[2],
                v.e_pc[13:2], v.e_pc[25:2], v.e_pc[5:2], n};
    endfunction

    task automatic check(string nm, logic [177:0] act, logic [177:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        rst = v.rst; flush = v.flush; in_valid = v.iv; cond_pass = v.cp; out_ready = v.ordy;
        pc_i = v.pc; val_rn_i = v.rn; wb_en_i = v.wb; mem_w_en_i = v.mw; exe_cmd_i = v.cmd;
    endtask

    initial begin
        //                 name         rst fl iv cp or  pc      rn        wb mw cmd   vld rdy occ e_pc   e_rn      ewb emw ecmd null
        vecs.push_back(mk("reset0",     0, 0, 1, 1, 1, 32'h40, 32'h140,  1, 0, 4'h1, 0, 1, 0, 32'h00, 32'h000,  0, 0, 4'h0, 0));
        vecs.push_back(mk("reset1",     0, 0, 0, 1, 0, 32'h00, 32'h000,  0, 0, 4'h0, 0, 1, 0, 32'h00, 32'h000,  0, 0, 4'h0, 0));
        vecs.push_back(mk("stream0",    1, 0, 1, 1, 1, 32'h00, 32'h100,  1, 0, 4'h1, 1, 1, 1, 32'h00, 32'h100,  1, 0, 4'h1, 0));
        vecs.push_back(mk("stream4",    1, 0, 1, 1, 1, 32'h04, 32'h104,  1, 0, 4'h2, 1, 1, 1, 32'h04, 32'h104,  1, 0, 4'h2, 0));
        vecs.push_back(mk("stream8",    1, 0, 1, 1, 1, 32'h08, 32'h108,  1, 0, 4'h3, 1, 1, 1, 32'h08, 32'h108,  1, 0, 4'h3, 0));
        vecs.push_back(mk("stream12",   1, 0, 1, 1, 1, 32'h0C, 32'h10C,  1, 0, 4'h4, 1, 1, 1, 32'h0C, 32'h10C,  1, 0, 4'h4, 0));
        vecs.push_back(mk("drain",      1, 0, 0, 1, 1, 32'h00, 32'h000,  0, 0, 4'h0, 0, 1, 0, 32'h0C, 32'h10C,  0, 0, 4'h0, 0));
        vecs.push_back(mk("bp_10",      1, 0, 1, 1, 0, 32'h10, 32'h110,  1, 0, 4'h5, 1, 1, 1, 32'h10, 32'h110,  1, 0, 4'h5, 0));
        vecs.push_back(mk("bp_14",      1, 0, 1, 1, 0, 32'h14, 32'h114,  1, 0, 4'h6, 1, 0, 2, 32'h10, 32'h110,  1, 0, 4'h5, 0));
        vecs.push_back(mk("bp_refuse",  1, 0, 1, 1, 0, 32'h18, 32'h118,  1, 0, 4'h7, 1, 0, 2, 32'h10, 32'h110,  1, 0, 4'h5, 0));
        vecs.push_back(mk("bp_out10",   1, 0, 0, 1, 1, 32'h00, 32'h000,  0, 0, 4'h0, 1, 1, 1, 32'h14, 32'h114,  1, 0, 4'h6, 0));
        vecs.push_back(mk("bp_out14",   1, 0, 0, 1, 1, 32'h00, 32'h000,  0, 0, 4'h0, 0, 1, 0, 32'h14, 32'h114,  0, 0, 4'h0, 0));
        vecs.push_back(mk("nullify",    1, 0, 1, 0, 0, 32'h20, 32'hDEAD, 1, 1, 4'h9, 1, 1, 1, 32'h20, 32'hDEAD, 0, 0, 4'h0, 1));
        vecs.push_back(mk("null_out",   1, 0, 0, 1, 1, 32'h00, 32'h000,  0, 0, 4'h0, 0, 1, 0, 32'h20, 32'hDEAD, 0, 0, 4'h0, 1));
        vecs.push_back(mk("memw",       1, 0, 1, 1, 0, 32'h24, 32'h124,  0, 1, 4'hA, 1, 1, 1, 32'h24, 32'h124,  0, 1, 4'hA, 1));
        vecs.push_back(mk("fill2",      1, 0, 1, 1, 0, 32'h28, 32'h128,  1, 0, 4'hB, 1, 0, 2, 32'h24, 32'h124,  0, 1, 4'hA, 1));
        vecs.push_back(mk("flush2",     1, 1, 1, 0, 1, 32'h2C, 32'h12C,  1, 1, 4'hC, 0, 1, 0, 32'h24, 32'h124,  0, 0, 4'h0, 1));
        vecs.push_back(mk("fill1",      1, 0, 1, 1, 0, 32'h30, 32'h130,  1, 0, 4'hC, 1, 1, 1, 32'h30, 32'h130,  1, 0, 4'hC, 1));
        vecs.push_back(mk("flush_null", 1, 1, 1, 0, 0, 32'h34, 32'h134,  1, 1, 4'hD, 0, 1, 0, 32'h30, 32'h130,  0, 0, 4'h0, 2));
        vecs.push_back(mk("load38",     1, 0, 1, 1, 1, 32'h38, 32'h138,  1, 0, 4'hE, 1, 1, 1, 32'h38, 32'h138,  1, 0, 4'hE, 2));
        vecs.push_back(mk("xfer_acc",   1, 0, 1, 1, 1, 32'h3C, 32'h13C,  1, 0, 4'hF, 1, 1, 1, 32'h3C, 32'h13C,  1, 0, 4'hF, 2));
        vecs.push_back(mk("null40",     1, 0, 1, 0, 1, 32'h40, 32'h140,  1, 1, 4'h1, 1, 1, 1, 32'h40, 32'h140,  0, 0, 4'h0, 3));
        vecs.push_back(mk("null44",     1, 0, 1, 0, 0, 32'h44, 32'h144,  1, 1, 4'h2, 1, 0, 2, 32'h40, 32'h140,  0, 0, 4'h0, 4));
        vecs.push_back(mk("skid2head",  1, 0, 0, 1, 1, 32'h00, 32'h000,  0, 0, 4'h0, 1, 1, 1, 32'h44, 32'h144,  0, 0, 4'h0, 4));
        vecs.push_back(mk("null48",     1, 0, 1, 0, 0, 32'h48, 32'h148,  1, 1, 4'h3, 1, 0, 2, 32'h44, 32'h144,  0, 0, 4'h0, 5));
        vecs.push_back(mk("rst_mid",    0, 1, 1, 0, 1, 32'h4C, 32'h14C,  1, 1, 4'h4, 0, 1, 0, 32'h00, 32'h000,  0, 0, 4'h0, 0));
        vecs.push_back(mk("post_rst",   1, 0, 1, 1, 0, 32'h50, 32'h150,  1, 0, 4'h2, 1, 1, 1, 32'h50, 32'h150,  1, 0, 4'h2, 0));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(posedge clk);
            #1;
            check({vecs[i].name, "/cnt16"}, obs1, pack_exp(vecs[i], 1'b0));
            check({vecs[i].name, "/cnt2"},  obs2, pack_exp(vecs[i], 1'b1));
        end

        // Five nullified accepts while streaming: wide counter reaches 5, narrow one sticks at 3.
        for (int k = 0; k < 5; k++) begin
            rst = 1'b1; flush = 1'b0; in_valid = 1'b1; cond_pass = 1'b0; out_ready = 1'b1;
            pc_i = 32'h60 + 32'(4 * k); val_rn_i = 32'h200 + 32'(k);
            wb_en_i = 1'b1; mem_w_en_i = 1'b1; exe_cmd_i = 4'h7;
            @(posedge clk);
            #1;
            check($sformatf("sat%0d/cnt16", k), {162'd0, a_null}, {162'd0, 16'(k + 1)});
            check($sformatf("sat%0d/cnt2", k), {176'd0, c_null}, {176'd0, (k >= 2) ? 2'd3 : 2'(k + 1)});
            check($sformatf("sat%0d/ctrl", k), {171'd0, a_vld, a_wb, a_mw, a_cmd},
                  {171'd0, 1'b1, 1'b0, 1'b0, 4'h0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
